muldiv_unit: RTL
================

# muldiv_unit

Iterative integer multiply/divide unit for the multi-cycle RISC-V core. It is the parametrised successor of the combinational ALU and executes the RV32M operations over multiple cycles. It sits beside the ALU in the execute stage: the control FSM pulses `Start`, waits on `Busy`, and captures `Result` when `Done` pulses. It adds `WIDTH` generalisation, signed/unsigned mixes, and a start/busy/done/flush handshake.

## Interface
- `WIDTH`, 32: operand and result width; even, ≥ 4.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `Start`  in  1: request. Sampled only in IDLE.
- `Flush`  in  1: abort the operation in flight. Has priority over `Start`.
- `Op`  in  3: RV32M funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `Src1`, `Src2`  in  WIDTH: operands, sampled with `Start`.
- `Busy`  out  1: high while the operation is not in IDLE.
- `Done`  out  1: one-cycle pulse when `Result` is valid.
- `Result`  out  WIDTH: registered result. Held until the next `Done`.
- `Zero`  out  1: `Result == 0`, registered with `Result`.
- `Sign`  out  1: `Result[WIDTH-1]`, registered with `Result`.

## Operation
- **States:** IDLE, CALC, FINISH.
- **IDLE + Start, normal case:**
  - Latch `Op`.
  - Latch operand magnitudes:
    - `Src1` is signed for MULH, MULHSU, DIV and REM.
    - `Src2` is signed for MULH, DIV and REM.
    - All other operands are unsigned.
  - Latch the result-negate flags. The product and quotient are negated when the operand signs differ; the remainder takes the dividend sign.
  - Load the iteration counter with `WIDTH`.
  - Go to CALC.
- **IDLE + Start, special cases (skip CALC, go straight to FINISH):**
  - Divide by zero (`Src2 == 0`, DIV/DIVU/REM/REMU): quotient = all ones; remainder = `Src1`.
  - Signed overflow (DIV/REM, `Src1` = most negative, `Src2` = all ones): quotient = `Src1`; remainder = 0.
- **CALC, multiply:** radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- **CALC, divide:** restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- **CALC exit:** the counter decrements each cycle. When it reaches 1, the next state is FINISH.
- **FINISH:**
  - Apply two's-complement negation per the latched flags.
  - Select the output:
    - MUL: low half of the product.
    - MULH, MULHSU, MULHU: high half of the product.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Register `Result`, `Zero` and `Sign`.
  - Pulse `Done` and go to IDLE.
- **Flush:** in any state, go to IDLE on the next edge. No `Done` is issued, and `Result`, `Zero` and `Sign` keep their previous values.
- **Start outside IDLE:** ignored.
- **Operand changes after Start:** no effect.
- **Reset values:**
  - State = IDLE.
  - `Busy` = 0, `Done` = 0.
  - `Result` = 0.
  - `Zero` = 1, `Sign` = 0.
  - Counter and datapath registers = 0.
- **Reset mid-operation:** takes effect immediately and asynchronously. No `Done` follows.

## Timing
- **Start accepted:** on edge E0 (IDLE, `Start`=1, `Flush`=0). `Busy` goes high after E0.
- **Normal latency:**
  - CALC occupies edges E1…E_WIDTH.
  - FINISH is entered after E_WIDTH. The registers update and `Done` goes high after E_WIDTH+1.
  - `Done` is therefore high for the cycle following E_WIDTH+1, which is WIDTH+2 cycles including the Start cycle (34 for WIDTH=32).
- **Special-case latency:** FINISH after E0; `Done` is high after E1.
- **Busy:** equals (state != IDLE). It is low in the cycle `Done` is high.
- **Back-to-back:** `Start` may be asserted in the same cycle `Done` is high; it is accepted on that edge.
- **Flush:** with `Flush` asserted in cycle c, `Busy` is 0 in cycle c+1. A `Flush` coincident with FINISH suppresses `Done` and the register update.

## Test plan
- **Reset:** assert `rst_n`=0 mid-CALC of a DIV → `Busy`, `Done` and `Result` drop to 0 immediately and `Zero`=1. After release, no `Done` ever appears.
- **Multiply:** WIDTH=32.
  - MUL 7 × −3 → `Result`=0xFFFFFFEB, `Done` at cycle 34.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- **Divide:**
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF (`Sign`=1).
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - REM 6/3 → 0 with `Zero`=1.
- **Special cases, each with `Done` in cycle 2:**
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM 0x80000000/−1 → 0.
- **Handshake:**
  - `Start` pulsed while `Busy` → ignored, and the first result is unchanged.
  - `Start` on the `Done` cycle → a second operation completes 34 cycles later.
  - Operands changed after E0 → no effect.
- **Flush:**
  - `Flush` at CALC iteration 10 → IDLE next cycle, no `Done`, `Result` holds its old value.
  - `Flush` and `Start` together in IDLE → not accepted.
  - Repeat all checks with WIDTH=8: MUL 0x7F × 0x7F → 0x01, MULHU → 0x3F, `Done` at cycle 10.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with start/busy/done/flush handshake.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Flush,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Src1,
  input  logic [WIDTH-1:0] Src2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Sign
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 sign_q, sign_d;
  logic                 done_q, done_d;

  // Operand decode, only meaningful while IDLE samples Start
  logic             s1_signed, s2_signed, a_neg, b_neg, div0, ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign s1_signed = (Op == 3'b001) | (Op == 3'b010) | (Op == 3'b100) | (Op == 3'b110);
  assign s2_signed = (Op == 3'b001) | (Op == 3'b100) | (Op == 3'b110);
  assign a_neg     = s1_signed & Src1[WIDTH-1];
  assign b_neg     = s2_signed & Src2[WIDTH-1];
  assign a_mag     = a_neg ? -Src1 : Src1;
  assign b_mag     = b_neg ? -Src2 : Src2;
  assign div0      = Op[2] & (Src2 == '0);
  assign ovf       = Op[2] & ~Op[0] & (Src1 == MOST_NEG) & (&Src2);

  // Iteration datapath: acc low half holds multiplier / dividend-then-quotient
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic             q_bit;
  logic [WIDTH-1:0] diff;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dvs_q : '0)};
  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign q_bit   = shifted >= {1'b0, dvs_q};
  assign diff    = shifted[WIDTH-1:0] - dvs_q;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_val;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    case (op_q)
      3'b000:                 fin_val = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin_val = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      default:                fin_val = neg_q ? -rem_q : rem_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (Start) begin
          op_d    = Op;
          dvs_d   = b_mag;
          acc_d   = {{WIDTH{1'b0}}, a_mag};
          rem_d   = '0;
          // Remainder follows the dividend sign; product/quotient follow the sign xor
          neg_d   = (Op[2] & Op[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
          if (div0) begin
            acc_d   = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
            rem_d   = Src1;
            neg_d   = 1'b0;
            state_d = FINISH;
          end else if (ovf) begin
            acc_d   = {{WIDTH{1'b0}}, Src1};
            rem_d   = '0;
            neg_d   = 1'b0;
            state_d = FINISH;
          end
        end
        CALC: begin
          if (op_q[2]) begin
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
            rem_d = q_bit ? diff : shifted[WIDTH-1:0];
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FINISH;
        end
        FINISH: begin
          result_d = fin_val;
          zero_d   = (fin_val == '0);
          sign_d   = fin_val[WIDTH-1];
          done_d   = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  assign Busy   = (state_q != IDLE);
  assign Done   = done_q;
  assign Result = result_q;
  assign Zero   = zero_q;
  assign Sign   = sign_q;

endmodule
